ysyx_23060332_fetch_ctrl: RTL and testbench

//  Multi-cycle instruction-fetch controller: owns the PC, issues one request at a time to
//  the instruction memory over a valid/ready request+response pair, and presents the fetched

---
 rtl/ysyx_23060332_fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_ysyx_23060332_fetch_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060332_fetch_ctrl.sv
// Multi-cycle instruction-fetch controller.
// Owns the PC, issues one instruction-memory request at a time, hands the fetched
// instruction to the IDU and applies EXU redirects, discarding wrong-path responses.
// Optional feature: define YSYX_23060332_FETCH_PERF_EN to add the perf_fetch_cnt and
// perf_stall_cnt performance counter outputs.
module ysyx_23060332_fetch_ctrl #(
   parameter int unsigned            ADDR_W   = 32,
   parameter int unsigned            DATA_W   = 32,
   parameter logic [ADDR_W-1:0]      RESET_PC = ADDR_W'(32'h8000_0000)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_data,
   output logic              mem_rsp_ready,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc
`ifdef YSYX_23060332_FETCH_PERF_EN
  ,output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_stall_cnt
`endif
);

   typedef enum logic [1:0] {StReq, StWait, StHold} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
   logic                drop_q, drop_d;
   logic [DATA_W-1:0]   inst_q, inst_d;
   logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;

   assign mem_req_addr = req_addr_q;
   assign inst         = inst_q;
   assign inst_pc      = inst_pc_q;

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StReq;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         drop_q     <= 1'b0;
         inst_q     <= '0;
         inst_pc_q  <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         drop_q     <= drop_d;
         inst_q     <= inst_d;
         inst_pc_q  <= inst_pc_d;
      end
   end

   // Next-state, redirect handling and handshake outputs
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      req_addr_d    = req_addr_q;
      drop_d        = drop_q;
      inst_d        = inst_q;
      inst_pc_d     = inst_pc_q;
      mem_req_valid = 1'b0;
      mem_rsp_ready = 1'b0;
      inst_valid    = 1'b0;
      // Outputs stay quiet during the reset cycle; registers are reset regardless.
      if (!rst) begin
         unique case (state_q)
            StReq: begin
               mem_req_valid = 1'b1;
               if (mem_req_ready) begin
                  state_d = StWait;
               end
               // The request address is held stable; the in-flight fetch is marked stale.
               if (redirect_valid) begin
                  pc_d   = redirect_pc;
                  drop_d = 1'b1;
               end
            end
            StWait: begin
               mem_rsp_ready = 1'b1;
               if (mem_rsp_valid) begin
                  if (redirect_valid) begin
                     // Response consumed and discarded now, so nothing stays stale.
                     pc_d       = redirect_pc;
                     req_addr_d = redirect_pc;
                     drop_d     = 1'b0;
                     state_d    = StReq;
                  end else if (drop_q) begin
                     drop_d     = 1'b0;
                     req_addr_d = pc_q;
                     state_d    = StReq;
                  end else begin
                     inst_d    = mem_rsp_data;
                     inst_pc_d = req_addr_q;
                     state_d   = StHold;
                  end
               end else if (redirect_valid) begin
                  pc_d   = redirect_pc;
                  drop_d = 1'b1;
               end
            end
            StHold: begin
               inst_valid = 1'b1;
               // A redirect beats the IDU handshake: the held instruction is wrong-path.
               if (redirect_valid) begin
                  pc_d       = redirect_pc;
                  req_addr_d = redirect_pc;
                  state_d    = StReq;
               end else if (inst_ready) begin
                  pc_d       = pc_q + ADDR_W'(4);
                  req_addr_d = pc_q + ADDR_W'(4);
                  state_d    = StReq;
               end
            end
            default: state_d = StReq;
         endcase
      end
   end

`ifdef YSYX_23060332_FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, stall_cnt_q;

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;

   // Count accepted IDU handshakes and cycles spent waiting on memory
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (inst_valid && inst_ready && !redirect_valid) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if (state_q == StReq || state_q == StWait) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ysyx_23060332_fetch_ctrl.sv
// Self-checking bench for ysyx_23060332_fetch_ctrl: directed scenarios followed by a
// randomized run, all checked against a program-order model of the fetch stream and a
// single-outstanding memory model.
module tb_ysyx_23060332_fetch_ctrl;

   localparam logic [31:0] RstPc = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        mem_rsp_ready;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
`ifdef YSYX_23060332_FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   ysyx_23060332_fetch_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .mem_rsp_ready  (mem_rsp_ready),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc)
`ifdef YSYX_23060332_FETCH_PERF_EN
     ,.perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: expected program order and a one-deep memory
   logic [31:0] exp_pc;
   logic [31:0] last_inst_pc;
   int          n_inst;
   int          cyc;
   logic [31:0] req_q[$];
   int          iv_hist[$];
   bit          busy;
   int          mdelay;
   logic [31:0] maddr;
   bit          prev_stall;
   logic [31:0] prev_addr;
   bit          prev_hold;
   logic [31:0] prev_inst;
   logic [31:0] prev_inst_pc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   // One clock cycle: called just after a negedge, returns at the next negedge.
   task automatic step(input logic rr, input logic ir, input logic rv,
                       input logic [31:0] rpc, input int dly);
      bit req_hs, rsp_hs;
      cyc++;
      mem_rsp_valid  = busy && (mdelay == 0);
      mem_rsp_data   = mem_rsp_valid ? mem_word(maddr) : 32'hdead_beef;
      mem_req_ready  = rr;
      inst_ready     = ir;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
      if (prev_stall) begin
         check("req_hold_valid", {31'b0, mem_req_valid}, 32'd1);
         check("req_hold_addr", mem_req_addr, prev_addr);
      end
      if (prev_hold) begin
         check("hold_valid", {31'b0, inst_valid}, 32'd1);
         check("hold_inst", inst, prev_inst);
         check("hold_pc", inst_pc, prev_inst_pc);
      end
      if (mem_req_valid) check("one_outstanding", {31'b0, busy}, 32'd0);
      if (inst_valid) iv_hist.push_back(cyc);
      req_hs = mem_req_valid && rr;
      rsp_hs = mem_rsp_valid && mem_rsp_ready;
      if (req_hs) req_q.push_back(mem_req_addr);
      // Program-order model: a redirect overrides any handshake in the same cycle.
      if (rv) begin
         exp_pc = rpc;
      end else if (inst_valid && ir) begin
         check("inst_pc", inst_pc, exp_pc);
         check("inst_data", inst, mem_word(exp_pc));
         last_inst_pc = inst_pc;
         exp_pc = exp_pc + 32'd4;
         n_inst++;
      end
      if (rsp_hs) busy = 1'b0;
      else if (busy && mdelay > 0) mdelay--;
      if (req_hs) begin
         busy   = 1'b1;
         mdelay = dly;
         maddr  = mem_req_addr;
      end
      prev_stall   = mem_req_valid && !rr;
      prev_addr    = mem_req_addr;
      prev_hold    = inst_valid && !ir && !rv;
      prev_inst    = inst;
      prev_inst_pc = inst_pc;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_req_ready = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      mem_rsp_valid = 1'b0; mem_rsp_data = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
      check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      check("rst_rsp_ready", {31'b0, mem_rsp_ready}, 32'd0);
      check("rst_req_addr", mem_req_addr, RstPc);
      check("rst_inst", inst, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      busy = 1'b0; mdelay = 0; maddr = '0;
      prev_stall = 1'b0; prev_hold = 1'b0;
      exp_pc = RstPc; n_inst = 0; cyc = 0;
      req_q.delete(); iv_hist.delete();
      rst = 1'b0;
   endtask

   task automatic run_until(input int target, input string tag);
      int guard = 0;
      while (n_inst < target && guard < 100) begin
         step(1'b1, 1'b1, 1'b0, 32'd0, 0);
         guard++;
      end
      check(tag, n_inst, target);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: zero-wait memory, steady stream
      do_reset();
      for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 32'd0, 0);
      check("t1_nreq", req_q.size(), 32'd3);
      check("t1_req0", req_q[0], 32'h8000_0000);
      check("t1_req1", req_q[1], 32'h8000_0004);
      check("t1_req2", req_q[2], 32'h8000_0008);
      check("t1_niv", iv_hist.size(), 32'd3);
      check("t1_iv0", iv_hist[0], 32'd3);
      check("t1_iv1", iv_hist[1], 32'd6);
      check("t1_iv2", iv_hist[2], 32'd9);
`ifdef YSYX_23060332_FETCH_PERF_EN
      check("t1_perf_fetch", perf_fetch_cnt, 32'd3);
      check("t1_perf_stall", perf_stall_cnt, 32'd6);
`endif

      // 2: request back-pressure
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 1'b0, 32'd0, 0);
         check("t2_addr", prev_addr, 32'h8000_0000);
      end
      run_until(1, "t2_progress");
      check("t2_req0", req_q[0], 32'h8000_0000);

      // 3: redirect while waiting for the response
      do_reset();
      step(1'b1, 1'b1, 1'b0, 32'd0, 1);
      step(1'b1, 1'b1, 1'b1, 32'h8000_1000, 0);
      step(1'b1, 1'b1, 1'b0, 32'd0, 0);
      step(1'b1, 1'b1, 1'b0, 32'd0, 0);
      check("t3_nreq", req_q.size(), 32'd2);
      check("t3_req1", req_q[1], 32'h8000_1000);
      check("t3_niv", iv_hist.size(), 32'd0);
      run_until(1, "t3_progress");

      // 4: redirect beats inst_ready in HOLD
      do_reset();
      step(1'b1, 1'b1, 1'b0, 32'd0, 0);
      step(1'b1, 1'b1, 1'b0, 32'd0, 0);
      step(1'b1, 1'b1, 1'b1, 32'h8000_0200, 0);
      check("t4_no_hs", n_inst, 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'd0, 0);
      check("t4_niv", iv_hist.size(), 32'd1);
      check("t4_req1", req_q[1], 32'h8000_0200);
      run_until(1, "t4_progress");

      // 5: redirect in REQ without acceptance
      do_reset();
      step(1'b0, 1'b1, 1'b1, 32'h8000_0040, 0);
      step(1'b0, 1'b1, 1'b0, 32'd0, 0);
      step(1'b1, 1'b1, 1'b0, 32'd0, 0);
      step(1'b1, 1'b1, 1'b0, 32'd0, 0);
      step(1'b1, 1'b1, 1'b0, 32'd0, 0);
      check("t5_nreq", req_q.size(), 32'd2);
      check("t5_req0", req_q[0], 32'h8000_0000);
      check("t5_req1", req_q[1], 32'h8000_0040);
      check("t5_niv", iv_hist.size(), 32'd0);
      run_until(1, "t5_progress");

      // 6: IDU back-pressure in HOLD
      do_reset();
      step(1'b1, 1'b1, 1'b0, 32'd0, 0);
      step(1'b1, 1'b1, 1'b0, 32'd0, 0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 0);
      check("t6_nreq", req_q.size(), 32'd1);
      run_until(3, "t6_progress");
`ifdef YSYX_23060332_FETCH_PERF_EN
      check("t6_perf_fetch", perf_fetch_cnt, 32'd3);
`endif

      // PC wrap-around
      do_reset();
      step(1'b1, 1'b1, 1'b1, 32'hffff_fffc, 0);
      run_until(2, "wrap_progress");
      check("wrap_pc", last_inst_pc, 32'd0);

      // Randomized run
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] tgt;
         tgt = ($urandom_range(0, 3) == 0) ? 32'hffff_fff8 : ($urandom & 32'hffff_fffc);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 9) == 0, tgt, int'($urandom_range(0, 3)));
      end
      check("rand_progress", {31'b0, n_inst > 100}, 32'd1);
`ifdef YSYX_23060332_FETCH_PERF_EN
      check("rand_perf_fetch", perf_fetch_cnt, n_inst);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
